// File: rtl/ad9226_capture_ctrl.sv
// AD9226 capture controller: ADC clock divider, triggered capture into a sample buffer.
//   sys_clk/sys_rst             clock, synchronous active-high reset
//   i_start/i_abort             one-cycle capture request / abort
//   i_trig_en/i_trig_level      rising-edge level trigger enable and threshold
//   i_len                       requested sample count (0 or > DEPTH means DEPTH)
//   o_clk_driver                ADC sample clock, sys_clk/DIV, 50% duty
//   i_da9226_data               ADC bus, bit 12 = OTR
//   i_rd_addr/o_rd_data         buffer read port, 1-cycle latency
//   o_armed/o_busy/o_done/o_otr_seen/o_wr_count  status
module ad9226_capture_ctrl #(
  parameter int DIV   = 4,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_trig_en,
  input  logic [11:0]   i_trig_level,
  input  logic [AW:0]   i_len,
  output logic          o_clk_driver,
  input  logic [12:0]   i_da9226_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [11:0]   o_rd_data,
  output logic          o_armed,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_otr_seen,
  output logic [AW:0]   o_wr_count
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, CAPT, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] div_cnt, div_nxt;
  logic          strobe;
  logic [12:0]   smp;
  logic          smp_vld;
  logic [11:0]   prev_smp;
  logic          prev_vld;
  logic [AW:0]   len_q;
  logic          accept, wr_en, prev_ld, trig_hit;
  logic [11:0]   mem [DEPTH];

  always_comb begin
    strobe  = (div_cnt == CW'(DIV-1));
    div_nxt = strobe ? '0 : div_cnt + CW'(1);
  end

  // The sample latched on the strobe is acted on in the following cycle (smp_vld).
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div_cnt      <= '0;
      o_clk_driver <= 1'b0;
      smp_vld      <= 1'b0;
    end else begin
      div_cnt      <= div_nxt;
      o_clk_driver <= (div_nxt >= CW'(DIV/2));
      smp_vld      <= strobe;
      if (strobe) begin
        smp <= i_da9226_data;
      end
    end
  end

  always_comb begin
    trig_hit = prev_vld && (prev_smp < i_trig_level) && (smp[11:0] >= i_trig_level);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    wr_en     = 1'b0;
    prev_ld   = 1'b0;
    if (i_abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            state_nxt = ARM;
            accept    = 1'b1;
          end
        end
        ARM: begin
          if (smp_vld) begin
            if (!i_trig_en || trig_hit) begin
              wr_en     = 1'b1;
              state_nxt = (len_q == (AW+1)'(1)) ? DONE : CAPT;
            end else begin
              prev_ld = 1'b1;
            end
          end
        end
        CAPT: begin
          if (o_wr_count == len_q) begin
            state_nxt = DONE;
          end else if (smp_vld) begin
            wr_en = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    o_armed = (state == ARM);
    o_busy  = (state == ARM) || (state == CAPT);
    o_done  = (state == DONE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      o_wr_count <= '0;
      o_otr_seen <= 1'b0;
      prev_vld   <= 1'b0;
      len_q      <= FULL_LEN;
    end else if (i_abort) begin
      o_wr_count <= '0;
    end else if (accept) begin
      len_q      <= ((i_len == '0) || (i_len > FULL_LEN)) ? FULL_LEN : i_len;
      o_wr_count <= '0;
      o_otr_seen <= 1'b0;
      prev_vld   <= 1'b0;
    end else begin
      if (wr_en) begin
        o_wr_count <= o_wr_count + (AW+1)'(1);
        if (smp[12]) begin
          o_otr_seen <= 1'b1;
        end
      end
      if (prev_ld) begin
        prev_smp <= smp[11:0];
        prev_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en && !sys_rst) begin
      mem[o_wr_count[AW-1:0]] <= smp[11:0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      o_rd_data <= '0;
    end else begin
      o_rd_data <= mem[i_rd_addr];
    end
  end

endmodule
